// File: rtl/bias_rom_stream_ctrl.sv
// bias_rom_stream_ctrl: streams a fixed-latency parameter ROM as valid/ready beats over a programmable number of passes.
module bias_rom_stream_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int OUT_DEPTH   = 32,
  parameter int ADDR_WIDTH  = $clog2(OUT_DEPTH) + 1,
  parameter int ROM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int PASS_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PASS_WIDTH-1:0] num_passes,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_ce,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready
);
  localparam int FW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] ptr, addr_q;
  logic [PASS_WIDTH-1:0] pass_cnt, passes;
  logic [ROM_LATENCY-1:0] trk;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [FW-1:0] rd, wr;
  logic [CW-1:0] fifo_count, inflight;
  logic issue, push, pop, wrap, last, empty;
  always_comb begin
    inflight = '0;
    for (int i = 0; i < ROM_LATENCY; i++) inflight += CW'(trk[i]);
  end
  // Credit: words already queued plus words still in the ROM pipe must fit the FIFO.
  assign issue = !rst && state == RUN && ({1'b0, fifo_count} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH);
  assign push = trk[ROM_LATENCY-1];
  assign pop = data_out_valid && data_out_ready;
  assign wrap = ptr == ADDR_WIDTH'(OUT_DEPTH - 1);
  assign last = wrap && pass_cnt == passes - 1'b1;
  assign empty = fifo_count == '0;
  assign data_out_valid = !empty;
  assign data_out = mem[rd];
  assign rom_ce = 1'b1;
  assign busy = state != IDLE;
  assign done = state == DRAIN && empty && inflight == '0;
  assign rom_addr = issue ? ptr : addr_q;
  always_ff @(posedge clk) if (push) mem[wr] <= rom_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      addr_q <= '0;
      pass_cnt <= '0;
      passes <= '0;
      trk <= '0;
      rd <= '0;
      wr <= '0;
      fifo_count <= '0;
    end else begin
      addr_q <= rom_addr;
      trk <= ROM_LATENCY'({trk, issue});
      if (push) wr <= wr == FW'(FIFO_DEPTH - 1) ? '0 : wr + 1'b1;
      if (pop) rd <= rd == FW'(FIFO_DEPTH - 1) ? '0 : rd + 1'b1;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (issue) begin
        ptr <= wrap ? '0 : ptr + 1'b1;
        if (wrap) pass_cnt <= pass_cnt + 1'b1;
      end
      case (state)
        IDLE: if (start) begin
          passes <= num_passes;
          pass_cnt <= '0;
          ptr <= '0;
          state <= num_passes != '0 ? RUN : DRAIN;
        end
        RUN: if (issue && last) state <= DRAIN;
        DRAIN: if (done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/bias_rom_stream_ctrl.md
Name: bias_rom_stream_ctrl

Overview:
- Sequencer that reads a synchronous parameter ROM (bias/weight memory, fixed read latency, address + ce0 interface) and presents its words as a valid/ready stream.
- Streams every ROM word in address order, repeated for a programmable number of passes (e.g. one pass per token).
- Credit-based issue plus a small output FIFO keeps the stream correct under arbitrary backpressure, with no lost or duplicated words.
- Sits between a `*_bias`/`*_weight` ROM wrapper and the consuming linear/add datapath.

Parameters:
- DATA_WIDTH, 32, width of one ROM word / stream beat.
- OUT_DEPTH, 32, number of ROM words per pass (addresses 0..OUT_DEPTH-1).
- ADDR_WIDTH, $clog2(OUT_DEPTH)+1, ROM address width; matches the ROM wrapper.
- ROM_LATENCY, 2, cycles from address presented to rom_q valid; must be >=1.
- FIFO_DEPTH, 4, output FIFO entries; must be >= ROM_LATENCY+1.
- PASS_WIDTH, 16, width of num_passes.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  begin a job; sampled only in IDLE.
- num_passes  input  PASS_WIDTH  passes for the job; captured on accepted start.
- busy  output  1  high whenever state != IDLE.
- done  output  1  single-cycle pulse at job completion.
- rom_addr  output  ADDR_WIDTH  ROM address0.
- rom_ce  output  1  ROM ce0.
- rom_q  input  DATA_WIDTH  ROM q0.
- data_out  output  DATA_WIDTH  stream data; equals the FIFO head.
- data_out_valid  output  1  FIFO non-empty.
- data_out_ready  input  1  consumer ready.

Behaviour:
- Reset values:
  - state=IDLE; busy=0; done=0; data_out_valid=0.
  - FIFO empty; in-flight tracker cleared; address pointer=0; pass counter=0; rom_addr=0.
- rom_ce is tied to 1, including during reset, so the ROM pipeline free-runs. Whatever the ROM pipeline holds at reset is ignored because the tracker is cleared.
- States: IDLE, RUN, DRAIN.
  - IDLE: start=1 with num_passes!=0 goes to RUN. start=1 with num_passes==0 goes to DRAIN. start is ignored in every other state.
  - RUN: issue reads. On the issue of the last address of the last pass, go to DRAIN.
  - DRAIN: no issue. When the FIFO is empty and inflight==0, assert done combinationally for that cycle and go to IDLE.
- Issue condition: state==RUN and (fifo_count + inflight) < FIFO_DEPTH.
  - On issue, rom_addr = ptr this cycle.
  - ptr increments, wrapping OUT_DEPTH-1 -> 0; the pass counter increments on that wrap.
  - rom_addr holds its value when not issuing.
- In-flight tracker: a ROM_LATENCY-deep shift register of issue flags.
  - When the flag exits, rom_q is written into the FIFO that cycle.
  - inflight = popcount of the tracker.
  - The credit rule guarantees the FIFO never overflows.
- FIFO:
  - Show-ahead: data_out = head, data_out_valid = (count!=0).
  - Pop on valid & ready.
  - Simultaneous push and pop in the same cycle keeps count unchanged; a push into an empty FIFO is visible the next cycle.
  - data_out is stable while valid=1 and ready=0.
- Throughput and latency:
  - 1 beat/cycle sustained when ready is held high.
  - start sampled at the clock edge ending cycle T: first issue in T+1, first data_out_valid in T+1+ROM_LATENCY+1 (T+4 at default).
- Completion:
  - Total beats = num_passes*OUT_DEPTH, in address order 0..OUT_DEPTH-1 per pass.
  - The final handshake occurs in cycle H: done=1 in cycle H+1, busy=0 from H+2.
  - num_passes==0: done=1 in T+1 and no beats are emitted.
- Reset mid-job: the next cycle after reset is IDLE, with the FIFO and in-flight words discarded and valid=0. Words from the aborted job never appear after reset.
- ready may be asserted while valid=0; it has no effect.

Test Plan:
- Bench ROM loaded with ram[i]=0x100+i, OUT_DEPTH=4, num_passes=1, ready tied 1, start in cycle 0.
  - Required: valid in cycles 4..7 with data 0x100..0x103, done in cycle 8, busy low in cycle 9.
- num_passes=3, ready=1.
  - Required: 12 back-to-back beats 0x100..0x103 repeated three times, no bubbles after the first, a single done pulse.
- num_passes=2, ready low for 6 cycles starting at the 2nd beat, then random 50% ready.
  - Required: data held stable while stalled, the tracker never issues beyond 4 outstanding (issue stops), the exact 8-beat sequence with no loss or duplicate.
- num_passes=0.
  - Required: done in cycle 1, no valid ever, busy high only in cycle 1.
- Assert rst for 1 cycle after the 5th beat of a 3-pass job.
  - Required: valid=0 and busy=0 the cycle after reset; a new 1-pass job then yields 0x100..0x103 only.
- Pulse start with num_passes=5 while busy with a 1-pass job.
  - Required: ignored, exactly 4 beats emitted, one done pulse.
